tdm_demux_1_to_4: RTL and testbench

Registered 1-to-4 time-division demultiplexer: the receive end of a 4-channel TDM bit link whose transmit end is a 4-to-1 mux scanned by a 2-bit slot counter. The block locks to a frame-sync marker, routes each incoming serial bit to its channel slot, and presents a complete 4-bit frame with a one-cycle valid strobe. It sits between the board-level serial input pin and the parallel channel consumers on the Elbert V2 (Spartan-3) design.

---
 rtl/tdm_demux_1_to_4_pkg.sv | 16 +
 rtl/tdm_demux_1_to_4_slot_cnt.sv | 28 ++
 rtl/tdm_demux_1_to_4.sv | 137 +++++++++++++
 tb/tb_tdm_demux_1_to_4.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1_to_4_pkg.sv
// Shared constants, state encoding and sync helper for the 1-to-4 TDM demultiplexer.
package tdm_demux_1_to_4_pkg;

    localparam int N_CH   = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    function automatic logic sync_hit(input logic sync_lvl, input logic active_lvl);
        return (sync_lvl == active_lvl);
    endfunction

endpackage

// File: rtl/tdm_demux_1_to_4_slot_cnt.sv
// 2-bit wrapping slot counter: clear has priority over load-to-1, which beats increment.
module tdm_slot_cnt
    import tdm_demux_1_to_4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load1,
    input  logic              clr,
    output logic [SLOT_W-1:0] cnt
);

    // Slot index register; natural 2-bit overflow gives the 3 -> 0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= {SLOT_W{1'b0}};
        end else if (clr) begin
            cnt <= {SLOT_W{1'b0}};
        end else if (load1) begin
            cnt <= SLOT_W'(1);
        end else if (inc) begin
            cnt <= cnt + SLOT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/tdm_demux_1_to_4.sv
// Registered 1-to-4 TDM demultiplexer locking to a frame-sync marker.
// Optional strict sync checking in LOCKED is enabled by `define TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux_1_to_4
    import tdm_demux_1_to_4_pkg::*;
#(
    parameter logic SYNC_ACTIVE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    input  logic              sync,
    output logic [N_CH-1:0]   y,
    output logic              valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);

    tdm_state_e          state_r;
    logic [N_CH-2:0]     shadow_r;
    logic                sync_hit_s;
    logic                normal_s;
    logic                cap_s;
    logic [SLOT_W-1:0]   cap_idx_s;
    logic                frame_s;
    logic                err_s;
    logic                go_locked_s;
    logic                go_hunt_s;
    logic                inc_s;
    logic                load1_s;
    logic                clr_s;

    assign sync_hit_s = sync_hit(sync, SYNC_ACTIVE);

    tdm_slot_cnt u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_s),
        .load1 (load1_s),
        .clr   (clr_s),
        .cnt   (slot)
    );

    // Per-slot action decode: capture, frame completion, realign or loss of lock.
    always_comb begin
        normal_s    = 1'b0;
        cap_s       = 1'b0;
        cap_idx_s   = {SLOT_W{1'b0}};
        frame_s     = 1'b0;
        err_s       = 1'b0;
        go_locked_s = 1'b0;
        go_hunt_s   = 1'b0;
        inc_s       = 1'b0;
        load1_s     = 1'b0;
        clr_s       = 1'b0;
        if (en) begin
            case (state_r)
                ST_HUNT: begin
                    if (sync_hit_s) begin
                        cap_s       = 1'b1;
                        load1_s     = 1'b1;
                        go_locked_s = 1'b1;
                    end else begin
                        cap_s = 1'b0;
                    end
                end
                ST_LOCKED: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    // A realign restarts the frame at slot 0, so no valid can coincide with it.
                    if (sync_hit_s && (slot != {SLOT_W{1'b0}})) begin
                        err_s   = 1'b1;
                        cap_s   = 1'b1;
                        load1_s = 1'b1;
                    end else if (!sync_hit_s && (slot == {SLOT_W{1'b0}})) begin
                        err_s     = 1'b1;
                        go_hunt_s = 1'b1;
                        clr_s     = 1'b1;
                    end else begin
                        normal_s = 1'b1;
                    end
`else
                    normal_s = 1'b1;
`endif
                    if (normal_s) begin
                        inc_s = 1'b1;
                        if (slot == SLOT_W'(N_CH - 1)) begin
                            frame_s = 1'b1;
                        end else begin
                            cap_s     = 1'b1;
                            cap_idx_s = slot;
                        end
                    end else begin
                        inc_s = 1'b0;
                    end
                end
                default: begin
                    go_hunt_s = 1'b1;
                    clr_s     = 1'b1;
                end
            endcase
        end else begin
            normal_s = 1'b0;
        end
    end

    // FSM state, shadow capture and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_HUNT;
            shadow_r <= {(N_CH-1){1'b0}};
            y        <= {N_CH{1'b0}};
            valid    <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            valid    <= frame_s;
            sync_err <= err_s;
            for (int i = 0; i < N_CH - 1; i++) begin
                if (cap_s && (cap_idx_s == SLOT_W'(i))) begin
                    shadow_r[i] <= din;
                end
            end
            if (frame_s) begin
                y <= {din, shadow_r};
            end
            if (go_locked_s) begin
                state_r <= ST_LOCKED;
                locked  <= 1'b1;
            end else if (go_hunt_s) begin
                state_r <= ST_HUNT;
                locked  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Directed scoreboard bench for tdm_demux_1_to_4; expectations for sync-check builds
// are selected by TDM_DEMUX_SYNC_CHECK_EN.
module tb_tdm_demux_1_to_4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       din;
    logic       sync;
    logic [3:0] y;
    logic       valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int         vectors;
    int         miscompares;
    logic [3:0] exp_q[$];

    tdm_demux_1_to_4 #(.SYNC_ACTIVE(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din      (din),
        .sync     (sync),
        .y        (y),
        .valid    (valid),
        .slot     (slot),
        .locked   (locked),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_y"},        y,               4'b0000);
        chk({tag, "_valid"},    {3'b000, valid}, 4'b0000);
        chk({tag, "_slot"},     {2'b00, slot},   4'b0000);
        chk({tag, "_locked"},   {3'b000, locked}, 4'b0000);
        chk({tag, "_sync_err"}, {3'b000, sync_err}, 4'b0000);
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic step(input string tag, input logic d, input logic s, input logic e,
                        input logic ev, input logic [1:0] es, input logic el, input logic ee);
        logic [3:0] exp_y;
        @(negedge clk);
        din  = d;
        sync = s;
        en   = e;
        @(posedge clk);
        #1;
        chk({tag, "_valid"},    {3'b000, valid},    {3'b000, ev});
        chk({tag, "_slot"},     {2'b00, slot},      {2'b00, es});
        chk({tag, "_locked"},   {3'b000, locked},   {3'b000, el});
        chk({tag, "_sync_err"}, {3'b000, sync_err}, {3'b000, ee});
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_y_unexpected"}, y, 4'bxxxx);
            end else begin
                exp_y = exp_q.pop_front();
                chk({tag, "_y"}, y, exp_y);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        sync  = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First frame 1,0,1,1 after sync -> 1101
        exp_q.push_back(4'b1101);
        step("f1_s0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("f1_s1", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        step("f1_s2", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        step("f1_s3", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);

        // Back-to-back frames 0,1,1,0 -> 0110 and 1,1,1,1 -> 1111
        exp_q.push_back(4'b0110);
        step("f2_s0", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("f2_s1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        step("f2_s2", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        step("f2_s3", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        exp_q.push_back(4'b1111);
        step("f3_s0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("f3_s1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        step("f3_s2", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        step("f3_s3", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);

        // Stalled frame 1,0,0,1 with en toggling -> 1001; stall bits must be ignored
        exp_q.push_back(4'b1001);
        step("f4_s0",  1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("f4_st0", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step("f4_s1",  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        step("f4_st1", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        step("f4_s2",  1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        step("f4_st2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
        step("f4_s3",  1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        step("f4_st3", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

        // Missing sync at slot 0: lock loss with checking, flywheel without
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        step("miss_s0", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step("miss_h1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step("miss_h2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step("miss_h3", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
`else
        exp_q.push_back(4'b1010);
        step("fly_s0", 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("fly_s1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        step("fly_s2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        step("fly_s3", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
`endif

        // Sync arriving at slot 2: realign with checking, ignored without
        step("re_a", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("re_b", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        exp_q.push_back(4'b0100);
        step("re_c", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
        step("re_d", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        step("re_e", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        step("re_f", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        step("pre_rst0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("pre_rst1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
`else
        step("re_c", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        exp_q.push_back(4'b0011);
        step("re_d", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        step("re_e", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("re_f", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
`endif

        // Asynchronous reset mid-frame at slot 2, away from any clock edge
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // HUNT ignores data until sync, then frame 0,0,0,1 -> 1000
        step("hunt0", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step("hunt1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        exp_q.push_back(4'b1000);
        step("f5_s0", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step("f5_s1", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        step("f5_s2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        step("f5_s3", 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        step("f5_after", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk("f5_hold_y", y, 4'b1000);

        chk("queue_drained", 4'(exp_q.size()), 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
